// File: rtl/rv32_pkg.sv
`default_nettype none
// ============================================================================
// Package     : rv32_pkg
// Description : Shared rv32 decode definitions. Holds opcode constants, the
//               immediate-format select encodings shared with the immediate
//               generator, the decode-stage FSM states and the control-flag
//               bundle.
// Revision    : 1.0 - initial release
// ============================================================================
package rv32_pkg;

    // Major opcodes, instr[6:0]
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    // Immediate-format select, shared with the immediate generator
    localparam logic [2:0] IMM_I    = 3'b000;
    localparam logic [2:0] IMM_S    = 3'b001;
    localparam logic [2:0] IMM_B    = 3'b010;
    localparam logic [2:0] IMM_U    = 3'b011;
    localparam logic [2:0] IMM_J    = 3'b100;
    localparam logic [2:0] IMM_NONE = 3'b101;

    // Decode-stage run/halt state
    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

    // Control flags forwarded to execute
    typedef struct packed {
        logic reg_we;
        logic mem_re;
        logic mem_we;
        logic branch;
        logic jump;
        logic alu_src_imm;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '0;

endpackage : rv32_pkg
`default_nettype wire

// File: rtl/id_decode_stage_if.sv
`default_nettype none
// ============================================================================
// Interface   : id_decode_stage_if
// Description : Fetch-side handshake, execute-side handshake and decoded
//               outputs of the instruction-decode stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface id_decode_stage_if #(
    parameter int XLEN = 32
) ();
    // fetch side
    logic            if_valid;
    logic            if_ready;
    logic [XLEN-1:0] if_pc;
    logic [31:0]     if_instr;
    // execute side
    logic            flush;
    logic            ex_ready;
    logic            id_valid;
    logic [XLEN-1:0] id_pc;
    logic [24:0]     id_imm_data;
    logic [2:0]      id_imm_sel;
    logic [4:0]      id_rs1;
    logic [4:0]      id_rs2;
    logic [4:0]      id_rd;
    logic [2:0]      id_funct3;
    logic            id_funct7b5;
    logic            id_reg_we;
    logic            id_mem_re;
    logic            id_mem_we;
    logic            id_branch;
    logic            id_jump;
    logic            id_alu_src_imm;
    logic            id_illegal;

    // Environment view: fetch and execute units
    modport master (
        output if_valid, if_pc, if_instr, flush, ex_ready,
        input  if_ready, id_valid, id_pc, id_imm_data, id_imm_sel,
               id_rs1, id_rs2, id_rd, id_funct3, id_funct7b5,
               id_reg_we, id_mem_re, id_mem_we, id_branch, id_jump,
               id_alu_src_imm, id_illegal
    );

    // Decode-stage view
    modport slave (
        input  if_valid, if_pc, if_instr, flush, ex_ready,
        output if_ready, id_valid, id_pc, id_imm_data, id_imm_sel,
               id_rs1, id_rs2, id_rd, id_funct3, id_funct7b5,
               id_reg_we, id_mem_re, id_mem_we, id_branch, id_jump,
               id_alu_src_imm, id_illegal
    );
endinterface : id_decode_stage_if
`default_nettype wire

// File: rtl/rv32_opdecode.sv
`default_nettype none
// ============================================================================
// Module      : rv32_opdecode
// Description : Combinational opcode decoder. Maps opcode/funct3 to the
//               immediate-format select, control flags and illegal flag.
// Revision    : 1.0 - initial release
// ============================================================================
module rv32_opdecode
    import rv32_pkg::*;
#(
    parameter bit NOP_ON_FENCE = 1'b1
) (
    input  wire logic [6:0] opcode_i,
    input  wire logic [2:0] funct3_i,
    output logic      [2:0] imm_sel_o,
    output ctrl_t           ctrl_o,
    output logic            illegal_o
);

    // Legal decodes set their select/flags; anything rejected collapses to
    // "no immediate, no flags, illegal".
    always_comb begin
        imm_sel_o = IMM_NONE;
        ctrl_o    = CTRL_NONE;
        illegal_o = 1'b0;
        case (opcode_i)
            OP_LUI, OP_AUIPC: begin
                imm_sel_o     = IMM_U;
                ctrl_o.reg_we = 1'b1;
            end
            OP_JAL: begin
                imm_sel_o     = IMM_J;
                ctrl_o.reg_we = 1'b1;
                ctrl_o.jump   = 1'b1;
            end
            OP_JALR: begin
                imm_sel_o          = IMM_I;
                ctrl_o.reg_we      = 1'b1;
                ctrl_o.jump        = 1'b1;
                ctrl_o.alu_src_imm = 1'b1;
                illegal_o          = (funct3_i != 3'b000);
            end
            OP_BRANCH: begin
                imm_sel_o     = IMM_B;
                ctrl_o.branch = 1'b1;
                illegal_o     = (funct3_i == 3'b010) || (funct3_i == 3'b011);
            end
            OP_LOAD: begin
                imm_sel_o          = IMM_I;
                ctrl_o.reg_we      = 1'b1;
                ctrl_o.mem_re      = 1'b1;
                ctrl_o.alu_src_imm = 1'b1;
                illegal_o          = (funct3_i == 3'b011) || (funct3_i[2:1] == 2'b11);
            end
            OP_STORE: begin
                imm_sel_o          = IMM_S;
                ctrl_o.mem_we      = 1'b1;
                ctrl_o.alu_src_imm = 1'b1;
                illegal_o          = (funct3_i > 3'b010);
            end
            OP_IMM: begin
                imm_sel_o          = IMM_I;
                ctrl_o.reg_we      = 1'b1;
                ctrl_o.alu_src_imm = 1'b1;
            end
            OP_OP: begin
                ctrl_o.reg_we = 1'b1;
            end
            OP_FENCE: begin
                illegal_o = !NOP_ON_FENCE;
            end
            default: begin
                illegal_o = 1'b1;
            end
        endcase
        if (illegal_o) begin
            imm_sel_o = IMM_NONE;
            ctrl_o    = CTRL_NONE;
        end
    end

endmodule : rv32_opdecode
`default_nettype wire

// File: rtl/id_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_decode_stage
// Description : rv32 instruction-decode stage. Single-entry pipeline register
//               with valid/ready handshake, flush, and halt-on-illegal FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module id_decode_stage
    import rv32_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter bit NOP_ON_FENCE = 1'b1
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    id_decode_stage_if.slave  bus
);

    state_e          state_q;
    logic            valid_q;
    logic [XLEN-1:0] pc_q;
    logic [24:0]     imm_data_q;
    logic [2:0]      imm_sel_q;
    logic [4:0]      rs1_q;
    logic [4:0]      rs2_q;
    logic [4:0]      rd_q;
    logic [2:0]      funct3_q;
    logic            funct7b5_q;
    ctrl_t           ctrl_q;
    logic            illegal_q;

    logic [2:0]      dec_imm_sel;
    ctrl_t           dec_ctrl;
    logic            dec_illegal;
    logic            w_if_ready;
    logic            w_capture;

    rv32_opdecode #(
        .NOP_ON_FENCE (NOP_ON_FENCE)
    ) u_opdecode (
        .opcode_i  (bus.if_instr[6:0]),
        .funct3_i  (bus.if_instr[14:12]),
        .imm_sel_o (dec_imm_sel),
        .ctrl_o    (dec_ctrl),
        .illegal_o (dec_illegal)
    );

    // Accept only while running and the register is empty or being drained
    assign w_if_ready = (state_q == ST_RUN) && (!valid_q || bus.ex_ready);
    assign w_capture  = bus.if_valid && w_if_ready;

    // Pipeline register and run/halt FSM; flush beats capture and stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            valid_q    <= 1'b0;
            pc_q       <= '0;
            imm_data_q <= '0;
            imm_sel_q  <= IMM_NONE;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            funct3_q   <= '0;
            funct7b5_q <= 1'b0;
            ctrl_q     <= CTRL_NONE;
            illegal_q  <= 1'b0;
        end else if (bus.flush) begin
            state_q <= ST_RUN;
            valid_q <= 1'b0;
        end else if (w_capture) begin
            state_q    <= dec_illegal ? ST_HALT : ST_RUN;
            valid_q    <= 1'b1;
            pc_q       <= bus.if_pc;
            imm_data_q <= bus.if_instr[31:7];
            imm_sel_q  <= dec_imm_sel;
            rs1_q      <= bus.if_instr[19:15];
            rs2_q      <= bus.if_instr[24:20];
            rd_q       <= dec_ctrl.reg_we ? bus.if_instr[11:7] : 5'd0;
            funct3_q   <= bus.if_instr[14:12];
            funct7b5_q <= bus.if_instr[30];
            ctrl_q     <= dec_ctrl;
            illegal_q  <= dec_illegal;
        end else if (valid_q && bus.ex_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.if_ready       = w_if_ready;
    assign bus.id_valid       = valid_q;
    assign bus.id_pc          = pc_q;
    assign bus.id_imm_data    = imm_data_q;
    assign bus.id_imm_sel     = imm_sel_q;
    assign bus.id_rs1         = rs1_q;
    assign bus.id_rs2         = rs2_q;
    assign bus.id_rd          = rd_q;
    assign bus.id_funct3      = funct3_q;
    assign bus.id_funct7b5    = funct7b5_q;
    assign bus.id_reg_we      = ctrl_q.reg_we;
    assign bus.id_mem_re      = ctrl_q.mem_re;
    assign bus.id_mem_we      = ctrl_q.mem_we;
    assign bus.id_branch      = ctrl_q.branch;
    assign bus.id_jump        = ctrl_q.jump;
    assign bus.id_alu_src_imm = ctrl_q.alu_src_imm;
    assign bus.id_illegal     = illegal_q;

endmodule : id_decode_stage
`default_nettype wire

// File: tb/tb_id_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_decode_stage
// Description : Scoreboard bench for id_decode_stage with directed scenarios
//               followed by randomized fetch/stall/flush traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_decode_stage;

    typedef struct {
        logic [31:0] pc;
        logic [24:0] imm;
        logic [2:0]  sel;
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  f3;
        logic        f7b5, we, mre, mwe, br, jmp, asi, ill;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    id_decode_stage_if #(.XLEN(32)) bus ();

    id_decode_stage #(.XLEN(32), .NOP_ON_FENCE(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Reference decode straight from the opcode table
    function automatic exp_t model(input logic [31:0] in, input logic [31:0] pc);
        exp_t        e;
        logic [2:0]  f3;
        bit          legal;
        f3 = in[14:12];
        legal = 1;
        e = '{pc: pc, imm: in[31:7], sel: 3'd5, rs1: in[19:15], rs2: in[24:20],
              rd: 5'd0, f3: f3, f7b5: in[30], we: 0, mre: 0, mwe: 0, br: 0,
              jmp: 0, asi: 0, ill: 0};
        case (in[6:0])
            7'b0110111, 7'b0010111: begin e.sel = 3; e.we = 1; end
            7'b1101111: begin e.sel = 4; e.we = 1; e.jmp = 1; end
            7'b1100111: if (f3 == 0) begin e.sel = 0; e.we = 1; e.jmp = 1; e.asi = 1; end
                        else legal = 0;
            7'b1100011: if (f3 == 2 || f3 == 3) legal = 0;
                        else begin e.sel = 2; e.br = 1; end
            7'b0000011: if (f3 == 3 || f3 == 6 || f3 == 7) legal = 0;
                        else begin e.sel = 0; e.we = 1; e.mre = 1; e.asi = 1; end
            7'b0100011: if (f3 > 2) legal = 0;
                        else begin e.sel = 1; e.mwe = 1; e.asi = 1; end
            7'b0010011: begin e.sel = 0; e.we = 1; e.asi = 1; end
            7'b0110011: begin e.we = 1; end
            7'b0001111: ;
            default: legal = 0;
        endcase
        if (!legal) begin
            e.sel = 5; e.we = 0; e.mre = 0; e.mwe = 0; e.br = 0; e.jmp = 0; e.asi = 0;
            e.ill = 1;
        end
        if (e.we) e.rd = in[11:7];
        return e;
    endfunction

    // Abstract stage model: one slot, halted flag, expected queue
    exp_t q[$];
    bit   mv = 0;
    bit   mhalt = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mv = 0; mhalt = 0; q.delete();
        end else begin
            bit rdy;
            rdy = !mhalt && (!mv || bus.ex_ready);
            if (bus.flush) begin
                mv = 0; mhalt = 0; q.delete();
            end else if (bus.if_valid && rdy) begin
                exp_t e;
                if (q.size() > 0) void'(q.pop_front());
                e = model(bus.if_instr, bus.if_pc);
                q.push_back(e);
                mv = 1;
                mhalt = e.ill;
            end else if (mv && bus.ex_ready) begin
                if (q.size() > 0) void'(q.pop_front());
                mv = 0;
            end
        end
    end

    // Monitor: compare presented outputs against the scoreboard head
    always @(negedge clk) begin
        if (rst_n) begin
            chk("if_ready", {31'd0, bus.if_ready}, {31'd0, !mhalt && (!mv || bus.ex_ready)});
            chk("id_valid", {31'd0, bus.id_valid}, {31'd0, mv});
            if (mv && bus.id_valid) begin
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard_empty actual=1 required=0");
                end else begin
                    exp_t e;
                    e = q[0];
                    chk("id_pc", bus.id_pc, e.pc);
                    chk("id_imm_data", {7'd0, bus.id_imm_data}, {7'd0, e.imm});
                    chk("id_imm_sel", {29'd0, bus.id_imm_sel}, {29'd0, e.sel});
                    chk("id_rs1", {27'd0, bus.id_rs1}, {27'd0, e.rs1});
                    chk("id_rs2", {27'd0, bus.id_rs2}, {27'd0, e.rs2});
                    chk("id_rd", {27'd0, bus.id_rd}, {27'd0, e.rd});
                    chk("id_funct3", {29'd0, bus.id_funct3}, {29'd0, e.f3});
                    chk("id_flags",
                        {24'd0, bus.id_funct7b5, bus.id_reg_we, bus.id_mem_re, bus.id_mem_we,
                         bus.id_branch, bus.id_jump, bus.id_alu_src_imm, bus.id_illegal},
                        {24'd0, e.f7b5, e.we, e.mre, e.mwe, e.br, e.jmp, e.asi, e.ill});
                end
            end
        end
    end

    task automatic drive(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                         input bit fl, input bit exr);
        bus.if_valid = v;
        bus.if_instr = ins;
        bus.if_pc    = pc;
        bus.flush    = fl;
        bus.ex_ready = exr;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [10];
        logic [31:0] r;
        int          k;
        ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b0001111};
        r = $urandom;
        k = $urandom_range(0, 11);
        if (k < 10) return {r[31:7], ops[k]};
        if (k == 10) return r;
        return {r[31:2], 2'b01};
    endfunction

    initial begin
        bus.if_valid = 0; bus.if_instr = 0; bus.if_pc = 0; bus.flush = 0; bus.ex_ready = 1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        chk("reset_if_ready", {31'd0, bus.if_ready}, 32'd1);
        chk("reset_imm_sel", {29'd0, bus.id_imm_sel}, 32'd5);

        // addi x1,x2,5
        drive(1, 32'h00510093, 32'h100, 0, 1);
        @(negedge clk);
        chk("addi_valid", {31'd0, bus.id_valid}, 32'd1);
        chk("addi_imm", {7'd0, bus.id_imm_data}, 32'h000A201);
        chk("addi_sel", {29'd0, bus.id_imm_sel}, 32'd0);
        chk("addi_rs1", {27'd0, bus.id_rs1}, 32'd2);
        chk("addi_rd", {27'd0, bus.id_rd}, 32'd1);
        chk("addi_we_asi", {30'd0, bus.id_reg_we, bus.id_alu_src_imm}, 32'd3);

        // beq stalled 3 cycles while the next instruction waits
        drive(1, 32'h00208463, 32'h104, 0, 1);
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h00310113, 32'h108, 0, 0);
            chk("stall_if_ready", {31'd0, bus.if_ready}, 32'd0);
            chk("stall_branch", {31'd0, bus.id_branch}, 32'd1);
        end
        drive(1, 32'h00310113, 32'h108, 0, 1);
        chk("after_stall_pc", bus.id_pc, 32'h108);
        drive(0, 0, 0, 0, 1);

        // async reset while holding a valid instruction
        drive(1, 32'h00510093, 32'h10C, 0, 0);
        @(negedge clk);
        #2 rst_n = 0;
        #1;
        chk("rst_valid", {31'd0, bus.id_valid}, 32'd0);
        chk("rst_sel", {29'd0, bus.id_imm_sel}, 32'd5);
        chk("rst_flags", {26'd0, bus.id_reg_we, bus.id_mem_re, bus.id_mem_we,
                          bus.id_branch, bus.id_jump, bus.id_alu_src_imm}, 32'd0);
        bus.if_valid = 0;
        #1 rst_n = 1;
        #0 chk("rst_release_ready", {31'd0, bus.if_ready}, 32'd1);
        @(posedge clk); #1;

        // jal x1,2048
        drive(1, 32'h001000EF, 32'h200, 0, 1);
        @(negedge clk);
        chk("jal_sel", {29'd0, bus.id_imm_sel}, 32'd4);
        chk("jal_jump_we", {30'd0, bus.id_jump, bus.id_reg_we}, 32'd3);
        chk("jal_rd", {27'd0, bus.id_rd}, 32'd1);
        chk("jal_imm", {7'd0, bus.id_imm_data}, 32'h0002001);

        // flush together with a fetch drops the fetch
        drive(1, 32'h00510093, 32'h204, 1, 1);
        @(negedge clk);
        chk("flush_valid", {31'd0, bus.id_valid}, 32'd0);

        // illegal instruction halts until flushed
        drive(1, 32'h00000000, 32'h300, 0, 0);
        chk("illegal_flag", {31'd0, bus.id_illegal}, 32'd1);
        drive(1, 32'h00510093, 32'h304, 0, 0);
        chk("halt_ready0", {31'd0, bus.if_ready}, 32'd0);
        drive(1, 32'h00510093, 32'h304, 0, 1);
        chk("halt_ready1", {31'd0, bus.if_ready}, 32'd0);
        drive(0, 0, 0, 1, 1);
        chk("flush_restores_ready", {31'd0, bus.if_ready}, 32'd1);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            drive($urandom_range(0, 3) != 0, rand_instr(), $urandom,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0);
        end
        drive(0, 0, 0, 1, 1);
        drive(0, 0, 0, 0, 1);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_id_decode_stage
`default_nettype wire

// File: doc/id_decode_stage.md
Name: id_decode_stage

Overview:
Instruction-decode stage of the rv32 3-stage pipeline, directly upstream of the immediate generator. Registers each fetched instruction with a valid/ready handshake. Decodes the opcode into the 3-bit immediate-format select and the 25-bit immediate field (instr[31:7]) the immediate generator consumes, plus register indices and control flags. Handles downstream stall, branch flush, and a halt-on-illegal-instruction state machine.

Parameters:
XLEN, 32, datapath/PC width
NOP_ON_FENCE, 1, if 1 FENCE (0001111) decodes as a legal no-op; if 0 it is illegal

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
if_valid  in  1  fetch presents instruction
if_ready  out  1  decode can accept instruction this cycle
if_pc  in  XLEN  PC of fetched instruction
if_instr  in  32  fetched instruction word
flush  in  1  kill held instruction (taken branch/jump from EX)
ex_ready  in  1  execute accepts id outputs this cycle
id_valid  out  1  decode outputs valid
id_pc  out  XLEN  registered PC
id_imm_data  out  25  instr[31:7], to immediate generator data
id_imm_sel  out  3  000 I, 001 S, 010 B, 011 U, 100 J, 101 none (generator yields 0)
id_rs1, id_rs2  out  5 each  instr[19:15], instr[24:20]
id_rd  out  5  instr[11:7] when id_reg_we, else 0
id_funct3  out  3  instr[14:12]
id_funct7b5  out  1  instr[30]
id_reg_we, id_mem_re, id_mem_we, id_branch, id_jump, id_alu_src_imm  out  1 each  control flags
id_illegal  out  1  held instruction is illegal

Behaviour:
- Reset (rst_n low, any time, async): id_valid=0, all id_* outputs 0, id_imm_sel=101, FSM=RUN. if_ready=1 once rst_n is high.
- Single-entry pipeline register. if_ready = (state==RUN) && (!id_valid || ex_ready).
- Capture on the rising edge when if_valid && if_ready: all id_* load from the decode of if_instr/if_pc and id_valid=1. Latency is one cycle.
- If id_valid && ex_ready and nothing is captured: id_valid=0. Other outputs hold their values; they are don't-care.
- If id_valid && !ex_ready: all outputs are held stable (stall).
- flush has priority over capture and stall: next cycle id_valid=0, FSM=RUN, and the simultaneous fetch is dropped.
- Decode by opcode (instr[6:0]):
  - 0110111 LUI, 0010111 AUIPC: sel U, reg_we.
  - 1101111 JAL: sel J, reg_we, jump.
  - 1100111 JALR: sel I, reg_we, jump, alu_src_imm. Legal only when funct3=000.
  - 1100011 BRANCH: sel B, branch. funct3 010 and 011 are illegal.
  - 0000011 LOAD: sel I, reg_we, mem_re, alu_src_imm. funct3 011, 110 and 111 are illegal.
  - 0100011 STORE: sel S, mem_we, alu_src_imm. funct3 greater than 010 is illegal.
  - 0010011 OP-IMM: sel I, reg_we, alu_src_imm.
  - 0110011 OP: sel none, reg_we.
  - 0001111 FENCE: per NOP_ON_FENCE.
  - Anything else, including instr[1:0]!=11, is illegal.
- Illegal decode: all control flags 0, sel none, id_illegal=1. PC and rs/rd fields are still registered.
- FSM states RUN and HALT.
  - RUN->HALT when an illegal instruction is captured.
  - In HALT: if_ready=0, and the illegal instruction stays presented until ex_ready consumes it.
  - HALT->RUN only on flush.
  - Reset mid-HALT returns to RUN.

Decomposition:
- Package rv32_pkg holds: opcode constants, IMM_I/S/B/U/J/NONE select encodings shared with the immediate generator, the FSM state enum, and the control-flag struct.
- Combinational sub-module rv32_opdecode maps instr to {imm_sel, flags, illegal}. The stage wraps it with the register, handshake and FSM.

Test Plan:
1. Drive rst_n=0 mid-stream with id_valid=1 -> same cycle: id_valid=0, id_imm_sel=101, flags 0. After release, if_ready=1.
2. addi x1,x2,5 (0x00510093), if_valid=1, ex_ready=1 -> next cycle: id_valid=1, imm_sel=000, imm_data=25'h000A201, rs1=2, rd=1, reg_we=1, alu_src_imm=1.
3. beq (0x00208463) held with ex_ready=0 for 3 cycles while the next instruction is offered -> outputs stable, if_ready=0. When ex_ready rises, the next instruction is captured with no loss or duplicate.
4. jal x1,2048 (0x001000EF) -> imm_sel=100, jump=1, reg_we=1, rd=1, imm_data=25'h0002001.
5. flush asserted in the same cycle as if_valid=1 -> next cycle id_valid=0. The fetched instruction never appears.
6. Instruction 0x00000000 -> id_illegal=1, flags 0, if_ready=0 in the following cycles despite if_valid. A flush pulse restores if_ready=1.
